// File: rtl/bip_pkg.sv
// Shared definitions for the BIP1 core: default widths, mux select codes,
// ALU op codes and the instruction opcode set seen by the decoder.
package bip_pkg;

   localparam int NB_DATA    = 16;
   localparam int NB_OPERAND = 11;
   localparam int RAM_DEPTH  = 2048;

   localparam logic [1:0] SELA_RAM  = 2'b00;
   localparam logic [1:0] SELA_IMM  = 2'b01;
   localparam logic [1:0] SELA_ALU  = 2'b10;
   localparam logic [1:0] SELA_RSVD = 2'b11;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [2:0] {
      OPC_HLT  = 3'd0,
      OPC_STO  = 3'd1,
      OPC_LD   = 3'd2,
      OPC_LDI  = 3'd3,
      OPC_ADD  = 3'd4,
      OPC_ADDI = 3'd5,
      OPC_SUB  = 3'd6,
      OPC_SUBI = 3'd7
   } opcode_e;

endpackage

// File: rtl/bip_data_ram.sv
// Data RAM of the BIP1 datapath: one synchronous write port and two
// asynchronous read ports; accesses beyond DEPTH are ignored / read as zero.
module bip_data_ram
   import bip_pkg::*;
#(
   parameter int NB_DATA = bip_pkg::NB_DATA,
   parameter int NB_ADDR = bip_pkg::NB_OPERAND,
   parameter int DEPTH   = bip_pkg::RAM_DEPTH
) (
   input  logic               clk,
   input  logic               wrEn,
   input  logic [NB_ADDR-1:0] wrAddr,
   input  logic [NB_DATA-1:0] wrData,
   input  logic               rdEn,
   input  logic [NB_ADDR-1:0] rdAddr,
   output logic [NB_DATA-1:0] rdData,
   input  logic [NB_ADDR-1:0] dbgAddr,
   output logic [NB_DATA-1:0] dbgData
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [NB_DATA-1:0] mem [DEPTH];
   logic               wrInRange;
   logic               rdInRange;
   logic               dbgInRange;

   // Full-width compares so an operand wider than the RAM never aliases.
   assign wrInRange  = ({{(32-NB_ADDR){1'b0}}, wrAddr}  < 32'(DEPTH));
   assign rdInRange  = ({{(32-NB_ADDR){1'b0}}, rdAddr}  < 32'(DEPTH));
   assign dbgInRange = ({{(32-NB_ADDR){1'b0}}, dbgAddr} < 32'(DEPTH));

   always_ff @(posedge clk) begin
      if (wrEn && wrInRange) begin
         mem[wrAddr[AW-1:0]] <= wrData;
      end
   end

   always_comb begin
      rdData = '0;
      if (rdEn && rdInRange) begin
         rdData = mem[rdAddr[AW-1:0]];
      end
   end

   always_comb begin
      dbgData = '0;
      if (dbgInRange) begin
         dbgData = mem[dbgAddr[AW-1:0]];
      end
   end

endmodule

// File: rtl/bip_datapath.sv
// BIP1 execution datapath: accumulator, sign-extended immediate, add/sub ALU,
// SelA/SelB muxes, data RAM and the registered zero/neg/overflow flags.
module bip_datapath
   import bip_pkg::*;
#(
   parameter int NB_DATA    = bip_pkg::NB_DATA,
   parameter int NB_OPERAND = bip_pkg::NB_OPERAND,
   parameter int RAM_DEPTH  = bip_pkg::RAM_DEPTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_enable,
   input  logic [NB_OPERAND-1:0] i_operand,
   input  logic [1:0]            i_SelA,
   input  logic                  i_SelB,
   input  logic                  i_WrAcc,
   input  logic                  i_op,
   input  logic                  i_WrRam,
   input  logic                  i_RdRam,
   input  logic [NB_OPERAND-1:0] i_dbg_addr,
   output logic [NB_DATA-1:0]    o_acc,
   output logic                  o_zero,
   output logic                  o_neg,
   output logic                  o_ovf,
   output logic [NB_DATA-1:0]    o_dbg_data
);

   logic [NB_DATA-1:0] acc;
   logic               zeroFlag;
   logic               negFlag;
   logic               ovfFlag;

   logic [NB_DATA-1:0] immExt;
   logic [NB_DATA-1:0] ramRd;
   logic [NB_DATA-1:0] bOperand;
   logic [NB_DATA-1:0] aluRes;
   logic [NB_DATA-1:0] accNext;
   logic               accLoad;
   logic               ovfNow;
   logic               ramWrEn;

   assign immExt   = {{(NB_DATA-NB_OPERAND){i_operand[NB_OPERAND-1]}}, i_operand};
   assign bOperand = i_SelB ? immExt : ramRd;
   assign aluRes   = (i_op == OP_SUB) ? (acc - bOperand) : (acc + bOperand);

   // Subtraction overflows when the operand signs differ, addition when they match;
   // in both cases the result must also have left the accumulator's sign.
   assign ovfNow = ((i_op == OP_SUB) ? (acc[NB_DATA-1] != bOperand[NB_DATA-1])
                                     : (acc[NB_DATA-1] == bOperand[NB_DATA-1]))
                   && (aluRes[NB_DATA-1] != acc[NB_DATA-1]);

   // The store sees the pre-edge accumulator, so STO and an ACC load can share an edge.
   assign ramWrEn = !i_rst && i_enable && i_WrRam;

   bip_data_ram #(
      .NB_DATA (NB_DATA),
      .NB_ADDR (NB_OPERAND),
      .DEPTH   (RAM_DEPTH)
   ) u_ram (
      .clk     (i_clk),
      .wrEn    (ramWrEn),
      .wrAddr  (i_operand),
      .wrData  (acc),
      .rdEn    (i_RdRam),
      .rdAddr  (i_operand),
      .rdData  (ramRd),
      .dbgAddr (i_dbg_addr),
      .dbgData (o_dbg_data)
   );

   always_comb begin
      accNext = acc;
      accLoad = 1'b0;
      case (i_SelA)
         SELA_RAM: begin
            accNext = ramRd;
            accLoad = 1'b1;
         end
         SELA_IMM: begin
            accNext = immExt;
            accLoad = 1'b1;
         end
         SELA_ALU: begin
            accNext = aluRes;
            accLoad = 1'b1;
         end
         default: begin
            accNext = acc;
            accLoad = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc      <= '0;
         zeroFlag <= 1'b1;
         negFlag  <= 1'b0;
         ovfFlag  <= 1'b0;
      end else if (i_enable && i_WrAcc && accLoad) begin
         acc      <= accNext;
         zeroFlag <= (accNext == '0);
         negFlag  <= accNext[NB_DATA-1];
         ovfFlag  <= (i_SelA == SELA_ALU) ? ovfNow : 1'b0;
      end
   end

   assign o_acc  = acc;
   assign o_zero = zeroFlag;
   assign o_neg  = negFlag;
   assign o_ovf  = ovfFlag;

endmodule

// File: tb/tb_bip_datapath.sv
// Bench for bip_datapath: two instances (full RAM and a 1024-word RAM) driven in
// lockstep; an integer reference model predicts ACC, flags and the debug read port.
module tb_bip_datapath;

   localparam int W = 36;   // {dbgCheck, dbg[15:0], acc[15:0], zero, neg, ovf}

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [10:0] operand;
   logic [1:0]  selA;
   logic        selB;
   logic        wrAcc;
   logic        op;
   logic        wrRam;
   logic        rdRam;
   logic [10:0] dbgAddr;

   logic [15:0] accBig, dbgBig, accSml, dbgSml;
   logic        zeroBig, negBig, ovfBig, zeroSml, negSml, ovfSml;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] expSmall_q[$];

   int nVec = 0;
   int nErr = 0;
   string curTest = "init";

   int          accM  [2];
   bit          zeroM [2];
   bit          negM  [2];
   bit          ovfM  [2];
   logic [15:0] ramM  [2][2048];
   bit          wrM   [2][2048];
   int          depthM[2] = '{2048, 1024};
   int          pool  [20];
   int          dbgSel = 0;

   always #5 clk = ~clk;

   bip_datapath dut (
      .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_operand(operand),
      .i_SelA(selA), .i_SelB(selB), .i_WrAcc(wrAcc), .i_op(op),
      .i_WrRam(wrRam), .i_RdRam(rdRam), .i_dbg_addr(dbgAddr),
      .o_acc(accBig), .o_zero(zeroBig), .o_neg(negBig), .o_ovf(ovfBig),
      .o_dbg_data(dbgBig)
   );

   bip_datapath #(.RAM_DEPTH(1024)) dutSmall (
      .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_operand(operand),
      .i_SelA(selA), .i_SelB(selB), .i_WrAcc(wrAcc), .i_op(op),
      .i_WrRam(wrRam), .i_RdRam(rdRam), .i_dbg_addr(dbgAddr),
      .o_acc(accSml), .o_zero(zeroSml), .o_neg(negSml), .o_ovf(ovfSml),
      .o_dbg_data(dbgSml)
   );

   function automatic int toSigned16(input int v);
      return (v >= 32768) ? v - 65536 : v;
   endfunction

   // Drive one control word at the falling edge and predict the post-edge state.
   task automatic apply(input bit r, input bit en, input int opd, input int sa,
                        input bit sb, input bit wa, input bit o, input bit wr,
                        input bit rd, input int dbg);
      @(negedge clk);
      rst = r; enable = en; operand = opd[10:0]; selA = sa[1:0]; selB = sb;
      wrAcc = wa; op = o; wrRam = wr; rdRam = rd; dbgAddr = dbg[10:0];
      for (int k = 0; k < 2; k++) begin
         int rdv, bv, imm, s, newv, oldAcc, dv;
         bit inR, dInR, dChk;
         s = 0;
         if (r) begin
            accM[k] = 0; zeroM[k] = 1; negM[k] = 0; ovfM[k] = 0;
         end else if (en) begin
            inR    = opd < depthM[k];
            imm    = (opd >= 1024) ? opd - 2048 : opd;
            rdv    = (rd && inR) ? int'(ramM[k][opd]) : 0;
            bv     = sb ? (imm & 'hFFFF) : rdv;
            oldAcc = accM[k];
            if (wa && sa != 3) begin
               if (sa == 0) newv = rdv;
               else if (sa == 1) newv = imm & 'hFFFF;
               else begin
                  s = o ? toSigned16(oldAcc) - toSigned16(bv)
                        : toSigned16(oldAcc) + toSigned16(bv);
                  newv = s & 'hFFFF;
               end
               ovfM[k]  = (sa == 2) && (s > 32767 || s < -32768);
               accM[k]  = newv;
               zeroM[k] = (newv == 0);
               negM[k]  = (newv >= 32768);
            end
            if (wr && inR) begin
               ramM[k][opd] = oldAcc[15:0];
               wrM[k][opd]  = 1'b1;
            end
         end
         dInR = dbg < depthM[k];
         dChk = !dInR || wrM[k][dbg];
         dv   = dInR ? int'(ramM[k][dbg]) : 0;
         if (k == 0) exp_q.push_back({dChk, dv[15:0], accM[k][15:0], zeroM[k], negM[k], ovfM[k]});
         else        expSmall_q.push_back({dChk, dv[15:0], accM[k][15:0], zeroM[k], negM[k], ovfM[k]});
      end
   endtask

   task automatic ldi(input int v);  apply(0, 1, v, 1, 0, 1, 0, 0, 0, dbgSel); endtask
   task automatic sto(input int a);  apply(0, 1, a, 0, 0, 0, 0, 1, 0, a);      endtask
   task automatic ld(input int a);   apply(0, 1, a, 0, 0, 1, 0, 0, 1, dbgSel); endtask
   task automatic add(input int a);  apply(0, 1, a, 2, 0, 1, 0, 0, 1, dbgSel); endtask
   task automatic addi(input int v); apply(0, 1, v, 2, 1, 1, 0, 0, 0, dbgSel); endtask
   task automatic sub(input int a);  apply(0, 1, a, 2, 0, 1, 1, 0, 1, dbgSel); endtask
   task automatic subi(input int v); apply(0, 1, v, 2, 1, 1, 1, 0, 0, dbgSel); endtask

   task automatic compare(input string name, input logic [W-1:0] e,
                          input logic [15:0] acc, input logic z, input logic n,
                          input logic v, input logic [15:0] dbg);
      nVec++;
      if (({acc, z, n, v} !== e[18:0]) || (e[35] && (dbg !== e[34:19]))) begin
         nErr++;
         $display("FAIL %s/%s: got acc=%h z=%b n=%b v=%b dbg=%h, required acc=%h z=%b n=%b v=%b dbg=%h (checked=%b)",
                  curTest, name, acc, z, n, v, dbg, e[18:3], e[2], e[1], e[0], e[34:19], e[35]);
      end
   endtask

   always begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0)      compare("ram2048", exp_q.pop_front(), accBig, zeroBig, negBig, ovfBig, dbgBig);
      if (expSmall_q.size() > 0) compare("ram1024", expSmall_q.pop_front(), accSml, zeroSml, negSml, ovfSml, dbgSml);
   end

   initial begin
      rst = 1; enable = 1; operand = '0; selA = '0; selB = 0; wrAcc = 0;
      op = 0; wrRam = 0; rdRam = 0; dbgAddr = '0;
      for (int i = 0; i < 16; i++) pool[i] = i;
      pool[16] = 1023; pool[17] = 1024; pool[18] = 1500; pool[19] = 2047;

      curTest = "reset";
      repeat (2) apply(1, 1, 'h123, 1, 0, 1, 0, 0, 0, 0);

      curTest = "ldi_sto";
      ldi('h7FF);
      ldi('h400);
      dbgSel = 5;
      sto(5);
      ldi(0);

      curTest = "add_ovf";
      ldi('h3FF);
      sto(0);
      ld(0);
      repeat (33) add(0);
      ldi(1);

      curTest = "sub";
      ldi(0);
      subi(1);
      ldi('h400);
      sto(1);
      ld(1);
      repeat (31) add(1);
      subi(1);
      ldi(3);
      sto(2);
      ldi(0);
      sub(2);
      addi('h7FF);

      curTest = "freeze";
      ldi('h11);
      repeat (3) apply(0, 0, 3, 1, 0, 1, 0, 1, 0, 5);
      sto(3);
      ld(5);

      curTest = "bounds";
      ldi('h2A5);
      sto(2047);
      ldi(0);
      ld(2047);
      ldi('h55);
      sto(1500);
      ldi(9);
      ld(1500);
      ldi('h55);
      apply(0, 1, 7, 1, 0, 1, 0, 1, 0, 7);
      ld(7);

      curTest = "preload";
      for (int i = 0; i < 20; i++) begin
         ldi($urandom_range(0, 2047));
         sto(pool[i]);
      end

      curTest = "random";
      for (int i = 0; i < 400; i++) begin
         bit r, en, rd;
         int opd;
         r   = ($urandom_range(0, 63) == 0);
         en  = ($urandom_range(0, 7) != 0);
         rd  = $urandom_range(0, 1);
         opd = rd ? pool[$urandom_range(0, 19)] : $urandom_range(0, 2047);
         apply(r, en, opd, $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
               rd, pool[$urandom_range(0, 19)]);
      end

      @(posedge clk);
      #2;
      if (exp_q.size() != 0 || expSmall_q.size() != 0) begin
         nErr++;
         $display("FAIL drain: %0d/%0d expected entries left, required 0/0",
                  exp_q.size(), expSmall_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
